lamp_safety_monitor: RTL

- Sits directly downstream of the traffic-light controller FSM; consumes its NS/EW one-hot light codes and produces the lamp-drive signals actually sent to the signal heads.
- Passes legal patterns through with one register stage.
- Blocks illegal patterns (bad encoding, conflicting greens, stalled sequence) by forcing all-red.
- Latches a fault and enters flashing-red fail-safe until an operator clear, followed by an all-red recovery interval.

---
 rtl/light_pkg.sv | 28 ++
 rtl/lamp_flash_gen.sv | 35 +++
 rtl/lamp_safety_monitor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Light codes shared with the traffic-light controller, plus the fault codes
// and state encoding used by the lamp safety monitor.
package light_pkg;

   localparam logic [2:0] RED      = 3'b100;
   localparam logic [2:0] YELLOW   = 3'b010;
   localparam logic [2:0] GREEN    = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [1:0] {
      FC_NONE = 2'b00,
      FC_ENC  = 2'b01,
      FC_CONF = 2'b10,
      FC_WDOG = 2'b11
   } fault_code_t;

   typedef enum logic [1:0] {
      RECOVER = 2'b00,
      PASS    = 2'b01,
      SUSPECT = 2'b10,
      FAULT   = 2'b11
   } mon_state_t;

   function automatic logic is_one_hot3(input logic [2:0] code);
      return (code == RED) || (code == YELLOW) || (code == GREEN);
   endfunction

endpackage

// File: rtl/lamp_flash_gen.sv
// Half-period generator for the fail-safe red flash. Held at phase-on while
// disabled, so every fault episode starts with the lamps lit.
module lamp_flash_gen #(
   parameter int FLASH_HALF = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic phase,
   output logic toggle
);

   localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

   logic [CW-1:0] cnt_reg;
   logic          phase_reg;

   // toggle marks the last cycle of a half period; the phase flips on the next edge
   assign toggle = en && (cnt_reg == LAST);
   assign phase  = phase_reg;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b1;
      end else if (toggle) begin
         cnt_reg   <= '0;
         phase_reg <= ~phase_reg;
      end else begin
         cnt_reg   <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/lamp_safety_monitor.sv
// Lamp safety monitor: passes legal controller light codes to the signal heads
// with one register stage, blocks illegal ones, and latches faults into a red flash.
module lamp_safety_monitor
   import light_pkg::*;
#(
   parameter int ALL_RED_CYCLES = 10_000_000,
   parameter int CONFIRM_CYCLES = 16,
   parameter int FLASH_HALF     = 5_000_000,
   parameter int MAX_HOLD       = 60_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] ns_in,
   input  logic [2:0] ew_in,
   input  logic       fault_clr,
   output logic [2:0] ns_lamp,
   output logic [2:0] ew_lamp,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic       flash_active
);

   genvar gi;

   logic [2:0]  head_code [2];
   logic [1:0]  head_oh;
   logic [1:0]  head_red;
   logic        enc_err;
   logic        conf_err;
   logic        illegal;
   logic        in_changed;
   logic        wd_trip;
   logic        rec_done;
   logic        confirm_done;
   fault_code_t err_class;

   mon_state_t  state_reg, state_next;
   logic [31:0] rec_cnt_reg, rec_cnt_next;
   logic [31:0] suspect_cnt_reg, suspect_cnt_next;
   logic [31:0] hold_cnt_reg, hold_cnt_next;
   logic [5:0]  prev_in_reg;
   fault_code_t code_reg, code_next;
   logic        fault_reg;
   logic        flash_reg;

   logic        flash_en;
   logic        flash_phase;
   logic        flash_toggle;

   assign head_code[0] = ns_in;
   assign head_code[1] = ew_in;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_check
         assign head_oh[gi]  = is_one_hot3(head_code[gi]);
         assign head_red[gi] = (head_code[gi] == RED);
      end
   endgenerate

   assign enc_err    = ~(&head_oh);
   assign conf_err   = (&head_oh) & ~(|head_red);
   assign illegal    = enc_err | conf_err;
   assign err_class  = conf_err ? FC_CONF : FC_ENC;
   assign in_changed = ({ns_in, ew_in} != prev_in_reg);

   assign wd_trip      = (hold_cnt_reg >= 32'(MAX_HOLD));
   assign rec_done     = (rec_cnt_reg + 32'd1 >= 32'(ALL_RED_CYCLES));
   // suspect_cnt is 0 in PASS, so this also covers a one-cycle confirm window
   assign confirm_done = (suspect_cnt_reg + 32'd1 >= 32'(CONFIRM_CYCLES));

   always_comb begin
      state_next       = state_reg;
      rec_cnt_next     = rec_cnt_reg;
      suspect_cnt_next = suspect_cnt_reg;
      code_next        = code_reg;
      case (state_reg)
         RECOVER: begin
            if (rec_done) begin
               state_next   = PASS;
               rec_cnt_next = '0;
            end else begin
               rec_cnt_next = rec_cnt_reg + 32'd1;
            end
         end
         PASS, SUSPECT: begin
            // confirmed input error outranks a simultaneous watchdog trip
            if (illegal && confirm_done) begin
               state_next       = FAULT;
               code_next        = err_class;
               suspect_cnt_next = '0;
            end else if (wd_trip) begin
               state_next       = FAULT;
               code_next        = FC_WDOG;
               suspect_cnt_next = '0;
            end else if (illegal) begin
               state_next       = SUSPECT;
               suspect_cnt_next = suspect_cnt_reg + 32'd1;
            end else begin
               state_next       = PASS;
               suspect_cnt_next = '0;
            end
         end
         FAULT: begin
            if (fault_clr && !illegal) begin
               state_next   = RECOVER;
               code_next    = FC_NONE;
               rec_cnt_next = '0;
            end
         end
         default: state_next = RECOVER;
      endcase
   end

   // Watchdog only runs while staying within PASS/SUSPECT; any entry restarts it.
   always_comb begin
      hold_cnt_next = '0;
      if ((state_reg == PASS || state_reg == SUSPECT) &&
          (state_next == PASS || state_next == SUSPECT) && !in_changed) begin
         hold_cnt_next = wd_trip ? hold_cnt_reg : hold_cnt_reg + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= RECOVER;
         rec_cnt_reg     <= '0;
         suspect_cnt_reg <= '0;
         hold_cnt_reg    <= '0;
         prev_in_reg     <= '0;
         code_reg        <= FC_NONE;
         fault_reg       <= 1'b0;
         flash_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         rec_cnt_reg     <= rec_cnt_next;
         suspect_cnt_reg <= suspect_cnt_next;
         hold_cnt_reg    <= hold_cnt_next;
         prev_in_reg     <= {ns_in, ew_in};
         code_reg        <= code_next;
         fault_reg       <= (state_next == FAULT);
         flash_reg       <= (state_next == FAULT);
      end
   end

   assign flash_en = (state_reg == FAULT);

   lamp_flash_gen #(
      .FLASH_HALF (FLASH_HALF)
   ) u_flash (
      .clk    (clk),
      .rst    (rst),
      .en     (flash_en),
      .phase  (flash_phase),
      .toggle (flash_toggle)
   );

   // One output register per signal head. Entering PASS from RECOVER keeps red
   // for one more cycle because the input was not checked during recovery.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_head
         logic [2:0] lamp_reg;
         logic [2:0] lamp_next;

         always_comb begin
            lamp_next = RED;
            if (state_next == PASS && state_reg != RECOVER) begin
               lamp_next = head_code[gi];
            end else if (state_next == FAULT && state_reg == FAULT &&
                         !(flash_phase ^ flash_toggle)) begin
               lamp_next = LAMP_OFF;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               lamp_reg <= RED;
            end else begin
               lamp_reg <= lamp_next;
            end
         end
      end
   endgenerate

   assign ns_lamp      = g_head[0].lamp_reg;
   assign ew_lamp      = g_head[1].lamp_reg;
   assign fault        = fault_reg;
   assign fault_code   = code_reg;
   assign flash_active = flash_reg;

endmodule
